// File: rtl/f_sweep_ctrl_if.sv
// Handshake/bus bundle between the sweep controller and the function under test.
interface f_sweep_ctrl_if;
  logic        start;
  logic [3:0]  a_out;
  logic        f_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] result;
  logic [4:0]  err_count;

  // Controller side: drives the code and status, samples start and F's response
  modport master (
    input  start,
    input  f_in,
    output a_out,
    output busy,
    output done,
    output pass,
    output result,
    output err_count
  );

  // Harness side: requests sweeps, provides F's response, observes status
  modport slave (
    output start,
    output f_in,
    input  a_out,
    input  busy,
    input  done,
    input  pass,
    input  result,
    input  err_count
  );
endinterface

// File: rtl/f_sweep_ctrl.sv
// Exhaustive sweep of a 4-input/1-output combinational function: drives all
// 16 codes, captures the truth table, and compares it against EXP_MASK.
module f_sweep_ctrl #(
  parameter logic [15:0] EXP_MASK = 16'h00F8
) (
  input logic            clk,
  input logic            rst,
  f_sweep_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t      state;
  logic [15:0] captured;
  logic        mismatch;

  // Truth table including the bit sampled this cycle, and its per-code mismatch
  always_comb begin
    captured           = bus.result;
    captured[bus.a_out] = bus.f_in;
    mismatch           = (bus.f_in != EXP_MASK[bus.a_out]);
  end

  // Sweep FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.a_out     <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.pass      <= 1'b0;
      bus.result    <= '0;
      bus.err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            state         <= SWEEP;
            bus.busy      <= 1'b1;
            bus.a_out     <= '0;
            bus.result    <= '0;
            bus.err_count <= '0;
            bus.pass      <= 1'b0;
          end
        end
        SWEEP: begin
          bus.result <= captured;
          if (mismatch)
            bus.err_count <= bus.err_count + 5'd1;
          if (bus.a_out == 4'hF) begin
            state     <= DONE;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
            bus.a_out <= '0;
            // compare uses the vector with the final bit merged in
            bus.pass  <= (captured == EXP_MASK);
          end else begin
            bus.a_out <= bus.a_out + 4'd1;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          bus.busy  <= 1'b0;
          bus.done  <= 1'b0;
          bus.a_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/f_sweep_ctrl.md
# f_sweep_ctrl

Self-checking stimulus stage that sits directly upstream of the 4-bit combinational function block F (out = A[2]&~A[3] | ~A[3]&A[1]&A[0]). On a start request it drives F's 4-bit input through all 16 codes, one per clock, and captures F's output bit for each code into a 16-bit truth-table vector. It compares every captured bit against a golden mask, then reports a mismatch count and a pass flag. It serves as the on-board exhaustive-check harness for F and for any other 4-input / 1-output function in the same lab.

## Interface
Parameters:
- EXP_MASK, 16'h00F8, golden truth table; bit i = expected F output for A = i (default matches F: codes 3,4,5,6,7 → 1)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- start  in  1  level-sampled sweep request
- a_out  out  4  registered drive to F's A input
- f_in  in  1  F's out, combinational response to a_out
- busy  out  1  high while sweeping
- done  out  1  one-cycle pulse at end of sweep
- pass  out  1  high when captured table == EXP_MASK; held until next sweep starts
- result  out  16  captured truth table; bit i = f_in sampled while a_out == i
- err_count  out  5  number of codes where f_in != EXP_MASK[i] (0..16)

## Operation
- FSM states: IDLE, SWEEP, DONE.
- IDLE: a_out = 0, busy = 0. When start = 1 at an edge → SWEEP; on the same edge clear result, err_count and pass, and set a_out = 0.
- SWEEP: busy = 1. Each edge: result[a_out] <= f_in; err_count increments if f_in != EXP_MASK[a_out]. If a_out == 15 → DONE; otherwise a_out <= a_out + 1.
- On the SWEEP→DONE edge: pass <= (final result vector including the bit just captured == EXP_MASK).
- DONE: done = 1 for exactly this cycle, busy = 0, a_out = 0. Next edge → IDLE unconditionally; start is ignored in DONE.
- start is ignored while in SWEEP. No restart or abort except rst.
- result, err_count and pass hold their values in IDLE and DONE until the next accepted start.
- Arithmetic: a_out is a 4-bit counter and never wraps during a sweep, since exit occurs at 15. err_count is 5 bits; its maximum is 16, so it cannot overflow.
- rst (any state, including mid-sweep): state = IDLE, a_out = 0, busy = 0, done = 0, pass = 0, result = 16'h0000, err_count = 0. rst has priority over start.

## Timing
- f_in is sampled in the same cycle a_out is presented; there are no pipeline stages between a_out and f_in. F must be purely combinational.
- With start sampled high at edge E0:
  - SWEEP runs through edges E0+1 … E0+16, sampling codes 0 … 15.
  - done, pass and the final result are valid from E0+16 to E0+17.
  - The FSM returns to IDLE at E0+17.
- busy is high from E0 to E0+16.
- If start is held high, a new sweep is accepted at E0+18, giving a period of 18 cycles.
- All outputs are registered; no combinational path exists from start or f_in to any output.

## Test plan
- Real F connected, pulse start → done pulses 16 cycles after the start edge; result = 16'h00F8, err_count = 0, pass = 1; a_out steps 0…15 one per cycle.
- f_in tied 0, start → result = 16'h0000, err_count = 5, pass = 0.
- f_in tied 1, start → result = 16'hFFFF, err_count = 11, pass = 0.
- Pulse start again at the 5th SWEEP cycle → no effect; done still occurs at E0+16 with correct result.
- Assert rst when a_out = 7 → next cycle: all outputs at reset values, state IDLE. A subsequent start gives a full sweep with result = 16'h00F8 and pass = 1.
- start held high for 40 cycles → done pulses at E0+16 and E0+34; pass = 1 both times; busy is low only during the DONE and IDLE cycles between sweeps.
